// File: rtl/sr_drive_pkg.sv
// ============================================================================
// Module   : sr_drive_pkg
// Purpose  : Shared types and constants for the SR latch drive sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_drive_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_SET = 2'b01,
    OP_CLR = 2'b10,
    OP_ILL = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PULSE = 2'b01,
    ST_DEAD  = 2'b10
  } fsm_state_e;

  // A hold of N cycles is counted as N-1 down to 0 while the state is occupied.
  function automatic logic [CNT_W-1:0] hold_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sr_hold_counter.sv
// ============================================================================
// Module   : sr_hold_counter
// Purpose  : Loadable, non-wrapping down-counter timing PULSE and DEAD holds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_hold_counter
  import sr_drive_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - C_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/sr_drive_sequencer.sv
// ============================================================================
// Module   : sr_drive_sequencer
// Purpose  : Issues break-before-make set/reset pulses to an SR latch and
//            tracks the expected latch state. Optional readback check is
//            enabled by defining SR_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_drive_sequencer
  import sr_drive_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int DEAD_W  = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  output logic       busy,
  output logic       state_q,
  output logic       known,
  output logic       err,
  output logic       chk_err
);

  localparam logic [CNT_W-1:0] C_PULSE_LD = hold_load(PULSE_W);
  localparam logic [CNT_W-1:0] C_DEAD_LD  = hold_load(DEAD_W);

  fsm_state_e       fsm_d, fsm_q;
  logic             s_d, s_q;
  logic             r_d, r_q;
  logic             state_d;
  logic             known_d, known_q;
  logic             err_d, err_q;
  logic             chk_err_d, chk_err_q;
  cmd_op_e          op;
  logic             want;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  sr_hold_counter u_hold (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    fsm_d     = fsm_q;
    s_d       = s_q;
    r_d       = r_q;
    state_d   = state_q;
    known_d   = known_q;
    err_d     = err_q;
    chk_err_d = chk_err_q;
    cnt_load  = 1'b0;
    cnt_val   = C_PULSE_LD;
    op        = cmd_op_e'(cmd_op);
    want      = (op == OP_SET);

    case (fsm_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op)
            OP_SET, OP_CLR: begin
              // Redundant commands against a known latch state are absorbed.
              if (!(known_q && (state_q == want))) begin
                fsm_d    = ST_PULSE;
                s_d      = want;
                r_d      = !want;
                cnt_load = 1'b1;
                cnt_val  = C_PULSE_LD;
              end
            end
            OP_ILL:  err_d = 1'b1;
            default: ;
          endcase
        end
      end

      ST_PULSE: begin
        if (cnt_zero) begin
          fsm_d    = ST_DEAD;
          s_d      = 1'b0;
          r_d      = 1'b0;
          // s_q is still the pulse polarity here: high for SET, low for CLR.
          state_d  = s_q;
          known_d  = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = C_DEAD_LD;
        end
      end

      ST_DEAD: begin
        if (cnt_zero) begin
          fsm_d = ST_IDLE;
`ifdef SR_CHECK_EN
          if (q_fb != state_q) begin
            chk_err_d = 1'b1;
          end
`endif
        end
      end

      default: begin
        fsm_d = ST_IDLE;
        s_d   = 1'b0;
        r_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q     <= ST_IDLE;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      state_q   <= 1'b0;
      known_q   <= 1'b0;
      err_q     <= 1'b0;
      chk_err_q <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      s_q       <= s_d;
      r_q       <= r_d;
      state_q   <= state_d;
      known_q   <= known_d;
      err_q     <= err_d;
      chk_err_q <= chk_err_d;
    end
  end

`ifndef SR_CHECK_EN
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
`endif

  assign cmd_ready = (fsm_q == ST_IDLE);
  assign busy      = (fsm_q != ST_IDLE);
  assign s         = s_q;
  assign r         = r_q;
  assign known     = known_q;
  assign err       = err_q;
  assign chk_err   = chk_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_drive_sequencer.sv
// ============================================================================
// Module   : tb_sr_drive_sequencer
// Purpose  : Self-checking bench for sr_drive_sequencer (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_drive_sequencer;
  import sr_drive_pkg::*;

  localparam int PULSE_W = 2;
  localparam int DEAD_W  = 1;
  // {chk_err, s, r, cmd_ready, busy, state_q, known, err}
  localparam logic [7:0] C_RESET_OBS = 8'b0001_0000;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       q_fb;
  logic       cmd_ready, s, r, busy, state_q, known, err, chk_err;

  int n_checks = 0;
  int n_errors = 0;

  logic q_lat = 1'b0;
  logic q_force0 = 1'b0;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] pulse;  // 0 none, 1 set pulse, 2 reset pulse
    logic       sq;
    logic       kn;
    logic       er;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] exp_q [$];
  logic       p_sq = 1'b0, p_kn = 1'b0, p_er = 1'b0;

  sr_drive_sequencer #(.PULSE_W(PULSE_W), .DEAD_W(DEAD_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .s         (s),
    .r         (r),
    .q_fb      (q_fb),
    .busy      (busy),
    .state_q   (state_q),
    .known     (known),
    .err       (err),
    .chk_err   (chk_err)
  );

  always #5 clock = ~clock;

  // Behavioural SR latch providing the readback.
  always @(posedge clock) begin
    if (s)      q_lat <= 1'b1;
    else if (r) q_lat <= 1'b0;
  end
  assign q_fb = q_force0 ? 1'b0 : q_lat;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] obs();
    return {chk_err, s, r, cmd_ready, busy, state_q, known, err};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("reset_state", obs(), C_RESET_OBS);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    p_sq = 1'b0; p_kn = 1'b0; p_er = 1'b0;
  endtask

  // Drive one command from IDLE and check every cycle until IDLE again.
  task automatic run_vec(input int idx, input vec_t v);
    logic [7:0] e;
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    if (v.pulse != 2'd0) begin
      for (int i = 0; i < PULSE_W; i++)
        exp_q.push_back({1'b0, v.pulse == 2'd1, v.pulse == 2'd2, 1'b0, 1'b1, p_sq, p_kn, p_er});
      for (int i = 0; i < DEAD_W; i++)
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, v.sq, v.kn, v.er});
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v.sq, v.kn, v.er});
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check($sformatf("vec%0d", idx), obs(), e);
      // While busy, an illegal command must be ignored.
      cmd_valid = !e[4];
      cmd_op    = 2'b11;
    end
    cmd_valid = 1'b0;
    p_sq = v.sq; p_kn = v.kn; p_er = v.er;
  endtask

  initial begin
    vec_t       v_set;
    logic [7:0] chk_exp;
    int         m_cnt, mism, sr_both, hs_model, hs_dut;
    logic       m_sq, m_kn, m_er, m_tgt, rv;
    logic [1:0] rop;
    logic [7:0] m_obs;

    vecs[0] = '{2'b01, 2'd1, 1'b1, 1'b1, 1'b0};  // SET pulses
    vecs[1] = '{2'b01, 2'd0, 1'b1, 1'b1, 1'b0};  // SET again filtered
    vecs[2] = '{2'b00, 2'd0, 1'b1, 1'b1, 1'b0};  // NOP
    vecs[3] = '{2'b10, 2'd2, 1'b0, 1'b1, 1'b0};  // CLR pulses
    vecs[4] = '{2'b10, 2'd0, 1'b0, 1'b1, 1'b0};  // CLR filtered
    vecs[5] = '{2'b11, 2'd0, 1'b0, 1'b1, 1'b1};  // illegal sets err
    vecs[6] = '{2'b01, 2'd1, 1'b1, 1'b1, 1'b1};  // err sticky
    vecs[7] = '{2'b10, 2'd2, 1'b0, 1'b1, 1'b1};
    v_set   = '{2'b01, 2'd1, 1'b1, 1'b1, 1'b0};

    #2;
    do_reset();
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    do_reset();
    check("err_cleared", obs(), C_RESET_OBS);

    // Reset during the first cycle of a CLR pulse.
    cmd_valid = 1'b1; cmd_op = 2'b10;
    tick();
    cmd_valid = 1'b0;
    check("clr_pulse_c1", obs(), 8'b0010_1000);
    #2 reset_n = 1'b0;
    #1 check("clr_reset_async", obs(), C_RESET_OBS);
    #2 reset_n = 1'b1;
    tick();
    check("clr_ready_after_release", obs(), C_RESET_OBS);

    // Reset in the last cycle of a SET pulse must not commit state_q.
    cmd_valid = 1'b1; cmd_op = 2'b01;
    tick();
    cmd_valid = 1'b0;
    check("set_pulse_c1", obs(), 8'b0100_1000);
    tick();
    check("set_pulse_c2", obs(), 8'b0100_1000);
    #2 reset_n = 1'b0;
    #1 check("set_reset_async", obs(), C_RESET_OBS);
    #2 reset_n = 1'b1;
    tick();
    check("set_interrupted", obs(), C_RESET_OBS);
    p_sq = 1'b0; p_kn = 1'b0; p_er = 1'b0;
    run_vec(8, v_set);

    // Readback held low across a SET.
    do_reset();
    q_force0 = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b01;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("chk_dead", obs(), 8'b0000_1110);
`ifdef SR_CHECK_EN
    chk_exp = 8'b1001_0110;
`else
    chk_exp = 8'b0001_0110;
`endif
    tick();
    check("chk_after_dead", obs(), chk_exp);
    tick();
    check("chk_sticky", obs(), chk_exp);
    q_force0 = 1'b0;
    do_reset();

    // Random stream against an independent cycle model.
    m_cnt = 0; m_sq = 1'b0; m_kn = 1'b0; m_er = 1'b0; m_tgt = 1'b0;
    mism = 0; sr_both = 0; hs_model = 0; hs_dut = 0;
    for (int k = 0; k < 10000; k++) begin
      m_obs = {1'b0, (m_cnt > DEAD_W) && m_tgt, (m_cnt > DEAD_W) && !m_tgt,
               m_cnt == 0, m_cnt != 0, m_sq, m_kn, m_er};
      if (obs() !== m_obs) mism++;
      if (s && r) sr_both++;
      rv  = ($urandom_range(0, 9) < 6);
      rop = 2'($urandom_range(0, 3));
      cmd_valid = rv;
      cmd_op    = rop;
      #1;
      if (cmd_valid && cmd_ready) hs_dut++;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == DEAD_W) begin
          m_sq = m_tgt;
          m_kn = 1'b1;
        end
      end else if (rv) begin
        hs_model++;
        if (rop == 2'b11) begin
          m_er = 1'b1;
        end else if (rop != 2'b00) begin
          if (!(m_kn && (m_sq == (rop == 2'b01)))) begin
            m_tgt = (rop == 2'b01);
            m_cnt = PULSE_W + DEAD_W;
          end
        end
      end
      tick();
    end
    cmd_valid = 1'b0;
    check("rand_model_mismatches", 8'(mism > 255 ? 255 : mism), 8'd0);
    check("rand_s_and_r", 8'(sr_both > 255 ? 255 : sr_both), 8'd0);
    n_checks++;
    if (hs_dut != hs_model) begin
      n_errors++;
      $display("FAIL rand_handshakes: got %0d expected %0d", hs_dut, hs_model);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
